// File: rtl/demux4_1_buffered_if.sv
// rtl/demux4_1_buffered_if.sv - producer/consumer bundle for the buffered 1:4 demultiplexer
// DUT side uses the slave modport; environment side uses master.
interface demux4_1_buffered_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0]      in_data;
  logic                  in_sel1;
  logic                  in_sel0;
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][WIDTH-1:0] out_data;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
`ifdef DEMUX4_STATS_EN
  logic [3:0][7:0]       out_count;
`endif

  modport slave (
    input  in_data, in_sel1, in_sel0, in_valid, out_ready,
    output in_ready, out_data, out_valid
`ifdef DEMUX4_STATS_EN
    , output out_count
`endif
  );

  modport master (
    output in_data, in_sel1, in_sel0, in_valid, out_ready,
    input  in_ready, out_data, out_valid
`ifdef DEMUX4_STATS_EN
    , input out_count
`endif
  );
endinterface

// File: rtl/demux4_1_buffered.sv
// rtl/demux4_1_buffered.sv - registered 1:4 demux with one-entry buffer per channel
// Optional per-channel delivery counters under DEMUX4_STATS_EN.
module demux4_1_buffered #(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  demux4_1_buffered_if.slave  bus
);
  logic [1:0]            dest;
  logic                  fill;
  logic [3:0]            drain;
  logic [3:0]            valid_q, valid_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;

  assign dest = {bus.in_sel1, bus.in_sel0};

  // A full channel still accepts when it drains on the same edge, so there is no bubble.
  assign bus.in_ready = reset & (~valid_q[dest] | bus.out_ready[dest]);
  assign fill         = bus.in_valid & bus.in_ready;
  assign drain        = valid_q & bus.out_ready;

  always_comb begin
    valid_d = valid_q & ~drain;
    data_d  = data_q;
    if (fill) begin
      valid_d[dest] = 1'b1;
      data_d[dest]  = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

`ifdef DEMUX4_STATS_EN
  logic [3:0][7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    for (int k = 0; k < 4; k++) begin
      if (drain[k]) count_d[k] = count_q[k] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign bus.out_count = count_q;
`endif
endmodule

// File: tb/tb_demux4_1_buffered.sv
// tb/tb_demux4_1_buffered.sv - bench for demux4_1_buffered against a queue-based reference model
// Define DEMUX4_STATS_EN to also check the delivery counters.
module tb_demux4_1_buffered;
  localparam int WIDTH = 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  demux4_1_buffered_if #(.WIDTH(WIDTH)) bus ();

  demux4_1_buffered #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending-word queue per channel, last loaded word, delivery counts.
  logic [WIDTH-1:0] mq [4][$];
  logic [WIDTH-1:0] mlast [4];
  int               mcnt [4];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mlast[k] = '0;
      mcnt[k]  = 0;
    end
  endtask

  // Called with inputs set just after a falling edge; checks outputs, then advances one clock.
  task automatic cycle();
    int  d;
    bit  exp_ready;
    bit  fire;
    #1;
    d = {bus.in_sel1, bus.in_sel0};
    exp_ready = reset && (mq[d].size() == 0 || bus.out_ready[d]);
    fire = bus.in_valid && exp_ready;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid[%0d]", k), {63'd0, bus.out_valid[k]}, {63'd0, mq[k].size() != 0});
      chk($sformatf("out_data[%0d]", k), bus.out_data[k], mlast[k]);
`ifdef DEMUX4_STATS_EN
      chk($sformatf("out_count[%0d]", k), {56'd0, bus.out_count[k]}, WIDTH'(mcnt[k] % 256));
`endif
    end
    if (!reset) begin
      model_clear();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && bus.out_ready[k]) begin
          void'(mq[k].pop_front());
          mcnt[k]++;
        end
      end
      if (fire) begin
        mq[d].push_back(bus.in_data);
        mlast[d] = bus.in_data;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int d, input logic [WIDTH-1:0] data, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel1   = d[1];
    bus.in_sel0   = d[0];
    bus.in_data   = data;
    bus.out_ready = rdy;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();

    // Reset with live traffic presented
    reset = 1'b0;
    drive(1'b1, 0, 64'hDEAD, 4'b1111);
    @(posedge clk);
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b1;
    drive(1'b0, 0, 64'h0, 4'b1111);
    cycle();

    // Routing of all four selects, back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 64'hA0 + 64'(i), 4'b1111);
      cycle();
    end
    drive(1'b0, 0, 64'h0, 4'b1111);
    cycle();
    cycle();

    // Stall isolation on channel 2
    drive(1'b1, 2, 64'h11, 4'b1011);
    cycle();
    drive(1'b1, 2, 64'h22, 4'b1011);
    #1 chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    cycle();
    cycle();
    drive(1'b1, 1, 64'h33, 4'b1011);
    cycle();
    drive(1'b1, 2, 64'h22, 4'b1111);
    #1 chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    cycle();
    drive(1'b0, 0, 64'h0, 4'b1111);
    cycle();
    cycle();

    // Simultaneous drain and fill of channel 0
    drive(1'b1, 0, 64'h55, 4'b0000);
    cycle();
    drive(1'b1, 0, 64'h66, 4'b0001);
    cycle();
    drive(1'b0, 0, 64'h0, 4'b0000);
    #1 chk("refill_data", bus.out_data[0], 64'h66);
    cycle();
    drive(1'b0, 0, 64'h0, 4'b0001);
    cycle();

    // Reset with every channel full and stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 64'hC0 + 64'(i), 4'b0000);
      cycle();
    end
    reset = 1'b0;
    drive(1'b1, 1, 64'hEE, 4'b1111);
    cycle();
    reset = 1'b1;
    drive(1'b0, 0, 64'h0, 4'b1111);
    cycle();
    cycle();

    // 257 transfers through channel 3
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 3, {$urandom, $urandom}, 4'b1111);
      cycle();
    end
    drive(1'b0, 0, 64'h0, 4'b1111);
    cycle();
`ifdef DEMUX4_STATS_EN
    chk("wrap_count3", {56'd0, bus.out_count[3]}, 64'd1);
    chk("wrap_count0", {56'd0, bus.out_count[0]}, 64'd0);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), {$urandom, $urandom},
            4'($urandom_range(0, 15)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/demux4_1_buffered.md
# demux4_1_buffered

Registered 1-to-4 demultiplexer with valid/ready handshakes: routes each word on a single input channel to one of four output channels, chosen by a 2-bit select, and holds it in a one-entry buffer until that output accepts it. It is the distributing counterpart of the 4:1 select path. It sits between a single producer, such as a writeback or result bus, and four independent consumers that can each stall. Outputs that are not stalled keep flowing while another output is stalled.

## Interface
Parameters:
- WIDTH, 64, data word width in bits

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- in_data  input  WIDTH  word to route
- in_sel1  input  1  destination select, MSB
- in_sel0  input  1  destination select, LSB; {in_sel1,in_sel0}=00→out0, 01→out1, 10→out2, 11→out3
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- out_data  output  4×WIDTH  per-channel buffered word; out_data[k] is channel k
- out_valid  output  4  per-channel buffer occupied
- out_ready  input  4  per-channel consumer accepts
- out_count  output  4×8  per-channel delivered-word counters; present only with DEMUX4_STATS_EN

## Operation
- Each channel k has one buffer holding a data register out_data[k] and a flag out_valid[k].
- Destination: d = {in_sel1,in_sel0}.
- in_ready = reset & (~out_valid[d] | out_ready[d]). This is combinational from in_sel*, out_valid and out_ready. It never depends on in_valid.
- Input transfer: when in_valid & in_ready at a clock edge, out_data[d] ← in_data and out_valid[d] ← 1.
- Output transfer: when out_valid[k] & out_ready[k] at a clock edge, channel k is drained, and out_valid[k] ← 0 unless the same edge refills it.
- Simultaneous drain and fill of the same channel: the old word is delivered, the new word is loaded, and out_valid stays 1. There is no bubble.
- Channels not equal to d are unaffected by the input. They drain independently in the same cycle.
- A stalled channel, with out_valid=1 and out_ready=0, blocks only inputs addressed to it. The producer must hold in_data, in_sel* and in_valid stable until in_ready.
- out_data[k] holds its last value while out_valid[k]=0. Consumers must not use it.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- No state machine beyond the four occupancy flags. Per channel: EMPTY → (fill) FULL; FULL → (drain without fill) EMPTY; FULL → (drain with fill) FULL.

## Timing
- Reset, when reset=0 at an edge:
  - all out_valid ← 0 and all out_data ← 0.
  - out_count ← 0 when present.
  - Buffered words are discarded without delivery.
- While reset=0, in_ready=0 combinationally.
- Latency: a word accepted at edge N appears on out_data[d] with out_valid[d]=1 after edge N.
  - Earliest consumption is edge N+1.
- Throughput: one word per cycle into any channel whose consumer holds out_ready=1.
- Reset asserted mid-transfer:
  - any handshake in that cycle is ignored.
  - state is cleared at that edge.
- First cycle after reset deasserts: all channels are EMPTY and in_ready=1.

## Configuration
- DEMUX4_STATS_EN defined: out_count[k] is an 8-bit counter.
  - It increments on every output transfer of channel k and wraps 255→0.
  - It resets to 0.
  - Counting is unaffected by a simultaneous fill.
- DEMUX4_STATS_EN undefined: the out_count port and its counters do not exist. All other behaviour is identical.

## Test plan
- Reset to EMPTY:
  - Stimulus: hold reset=0 for 2 cycles with in_valid=1 and out_ready=4'b1111.
  - Required: out_valid=0000, out_data all 0 and in_ready=0 throughout.
  - Required: after release, in_ready=1.
- Routing of all selects:
  - Stimulus: out_ready=1111; send 0xA0, 0xA1, 0xA2, 0xA3 on back-to-back cycles with d=00, 01, 10, 11.
  - Required: channel k shows 0xAk with out_valid[k]=1 for exactly one cycle, one edge after its acceptance.
- Stall isolation:
  - Stimulus: out_ready[2]=0; send 0x11 to d=10, then 0x22 to d=10, then 0x33 to d=01.
  - Required: the second word sees in_ready=0 and is held; 0x33 is accepted.
  - Required: raising out_ready[2] delivers 0x11, then 0x22 is accepted on that same edge.
- Simultaneous drain/fill:
  - Stimulus: channel 0 FULL with 0x55; out_ready[0]=1 and in_valid=1, d=00, in_data=0x66.
  - Required: in_ready=1 and out_valid[0] stays 1.
  - Required: out_data[0]=0x66 after the edge, with 0x55 delivered at that edge.
- Reset mid-operation:
  - Stimulus: all four channels FULL with out_ready=0000; assert reset for 1 cycle.
  - Required: out_valid=0000 and no word is delivered after release.
- Counter wrap (DEMUX4_STATS_EN):
  - Stimulus: 257 transfers through channel 3.
  - Required: out_count[3]=1 and the other out_count values are 0.
  - Required: with the macro undefined, the same bench minus out_count passes all of the above.
